// File: rtl/fifo_pkg.sv
// Shared types and defaults for the SRAM FIFO and its frame reader.
package fifo_pkg;

    // Word width shared with the SRAM FIFO.
    localparam int unsigned BITS_DEF      = 12;
    // Payload words per frame.
    localparam int unsigned FRAME_LEN_DEF = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdReq   = 3'd1,
        StRdWait  = 3'd2,
        StOutData = 3'd3,
        StOutCsum = 3'd4
    } state_e;

endpackage

// File: rtl/frame_checksum.sv
// Modular (2^BITS) accumulator with synchronous clear and add-enable.
module frame_checksum #(
    parameter int unsigned BITS = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            add_en,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] sum
);

    logic [BITS-1:0] sum_d, sum_q;

    // Clear wins over add; the sum wraps naturally at BITS.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + din;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the SRAM FIFO, groups words into frames, appends a checksum beat,
// and presents the result on a valid/ready stream.
module fifo_frame_reader
    import fifo_pkg::*;
#(
    parameter int unsigned BITS      = BITS_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fifo_read,
    input  logic [BITS-1:0]      fifo_data,
    input  logic                 fifo_ready,
    input  logic                 fifo_overflow,
    output logic [BITS-1:0]      m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 err_overflow,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

    state_e               state_d, state_q;
    logic [BITS-1:0]      m_data_d, m_data_q;
    logic                 m_valid_d, m_valid_q;
    logic                 m_last_d, m_last_q;
    logic                 err_d, err_q;
    logic [CNT_WIDTH-1:0] frame_cnt_d, frame_cnt_q;
    logic [IdxW-1:0]      idx_d, idx_q;
    logic                 csum_clr, csum_add;
    logic [BITS-1:0]      csum;

    frame_checksum #(
        .BITS (BITS)
    ) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr    (csum_clr),
        .add_en (csum_add),
        .din    (fifo_data),
        .sum    (csum)
    );

    // Next-state and datapath control. The IDLE -> RD_REQ -> RD_WAIT loop
    // guarantees the registered fifo_ready has updated before the next read.
    always_comb begin
        state_d     = state_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        idx_d       = idx_q;
        csum_clr    = 1'b0;
        csum_add    = 1'b0;
        err_d       = err_q | fifo_overflow;

        case (state_q)
            StIdle: begin
                if (fifo_ready) begin
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                m_data_d  = fifo_data;
                m_valid_d = 1'b1;
                csum_add  = 1'b1;
                state_d   = StOutData;
            end
            StOutData: begin
                if (m_ready) begin
                    if (idx_q == LastIdx) begin
                        // Accumulator already includes this final word.
                        m_data_d = csum;
                        m_last_d = 1'b1;
                        state_d  = StOutCsum;
                    end else begin
                        idx_d     = idx_q + IdxW'(1);
                        m_valid_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end
            StOutCsum: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    m_last_d    = 1'b0;
                    idx_d       = '0;
                    csum_clr    = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            idx_q       <= idx_d;
        end
    end

    assign fifo_read    = (state_q == StRdReq);
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign err_overflow = err_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader with a behavioural FIFO model.
module tb_fifo_frame_reader;

    typedef struct packed {
        logic        last;
        logic [11:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_read;
    logic [11:0] fifo_data = '0;
    logic        fifo_ready = 1'b0;
    logic        fifo_overflow = 1'b0;
    logic [11:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        err_overflow;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int failures = 0;
    int n_reads = 0;
    int n_beats = 0;

    logic [11:0] fifo_q[$];
    beat_t       exp_q[$];
    logic [11:0] sb_sum = '0;
    int          sb_cnt = 0;

    fifo_frame_reader #(
        .BITS      (12),
        .FRAME_LEN (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_read     (fifo_read),
        .fifo_data     (fifo_data),
        .fifo_ready    (fifo_ready),
        .fifo_overflow (fifo_overflow),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .err_overflow  (err_overflow),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // FIFO model: data registered the cycle after a read, ready flag registered.
    always @(posedge clk) begin
        if (fifo_read) begin
            n_reads++;
            check("read_nonempty", 32'(fifo_q.size() > 0), 32'd1);
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        end
        fifo_ready <= (fifo_q.size() > 0);
    end

    // Monitor: compare each accepted beat and stability under backpressure.
    beat_t prev_beat;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_beat.data));
                check("stall_last", 32'(m_last), 32'(prev_beat.last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(m_data), 32'(e.data));
                    check("beat_last", 32'(m_last), 32'(e.last));
                end
                n_beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = '{last: m_last, data: m_data};
        end
    end

    task automatic push_word(input logic [11:0] w);
        fifo_q.push_back(w);
        exp_q.push_back('{last: 1'b0, data: w});
        sb_sum = sb_sum + w;
        sb_cnt++;
        if (sb_cnt == 4) begin
            exp_q.push_back('{last: 1'b1, data: sb_sum});
            sb_sum = '0;
            sb_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && t < 200) begin
            tick();
            t++;
        end
        check(name, 32'(t < 200), 32'd1);
        repeat (2) tick();
    endtask

    initial begin
        int base;
        int t;
        // Reset state
        repeat (2) tick();
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // 1: free-running frame, checksum 0x00A
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(12'(i));
        drain("t1_drain");
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_reads", 32'(n_reads), 32'd4);

        // 2: checksum wraps to 0x003
        push_word(12'hFFF);
        push_word(12'hFFF);
        push_word(12'h002);
        push_word(12'h003);
        drain("t2_drain");
        check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // 3: backpressure on word 0x002
        push_word(12'h001);
        drain("t3_drain_a");
        m_ready = 1'b0;
        push_word(12'h002);
        push_word(12'h003);
        push_word(12'h004);
        t = 0;
        while (!m_valid && t < 50) begin
            tick();
            t++;
        end
        check("t3_valid_seen", 32'(t < 50), 32'd1);
        base = n_reads;
        repeat (5) begin
            tick();
            check("t3_no_read", 32'(fifo_read), 32'd0);
            check("t3_held_data", 32'(m_data), 32'h002);
        end
        check("t3_read_count", 32'(n_reads), 32'(base));
        m_ready = 1'b1;
        drain("t3_drain_b");
        check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

        // 4: empty FIFO mid-frame
        push_word(12'h100);
        push_word(12'h200);
        drain("t4_drain_a");
        repeat (20) begin
            tick();
            check("t4_gap_valid", 32'(m_valid), 32'd0);
            check("t4_gap_read", 32'(fifo_read), 32'd0);
        end
        push_word(12'h300);
        push_word(12'h400);
        drain("t4_drain_b");
        check("t4_frame_cnt", 32'(frame_cnt), 32'd4);

        // 5: overflow pulse mid-frame
        base = n_beats;
        push_word(12'h011);
        push_word(12'h022);
        push_word(12'h033);
        push_word(12'h044);
        t = 0;
        while (n_beats < base + 2 && t < 100) begin
            tick();
            t++;
        end
        check("t5_midframe", 32'(t < 100), 32'd1);
        check("t5_err_before", 32'(err_overflow), 32'd0);
        fifo_overflow = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        check("t5_err_set", 32'(err_overflow), 32'd1);
        drain("t5_drain_a");
        check("t5_frame_cnt", 32'(frame_cnt), 32'd5);
        for (int i = 0; i < 4; i++) push_word(12'h001);
        drain("t5_drain_b");
        check("t5_err_sticky", 32'(err_overflow), 32'd1);
        check("t5_frame_cnt2", 32'(frame_cnt), 32'd6);

        // 6: reset mid-frame
        push_word(12'h055);
        push_word(12'h066);
        drain("t6_drain_a");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_sum = '0;
        sb_cnt = 0;
        check("t6_m_valid", 32'(m_valid), 32'd0);
        check("t6_m_last", 32'(m_last), 32'd0);
        check("t6_m_data", 32'(m_data), 32'd0);
        check("t6_err", 32'(err_overflow), 32'd0);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t6_fifo_read", 32'(fifo_read), 32'd0);
        push_word(12'h010);
        push_word(12'h020);
        push_word(12'h030);
        push_word(12'h040);
        drain("t6_drain_b");
        check("t6_frame_cnt2", 32'(frame_cnt), 32'd1);
        check("t6_err2", 32'(err_overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
